// File: rtl/iter_divider.sv
// iter_divider: multi-cycle non-restoring divider with RISC-V DIV/DIVU/REM/REMU semantics
// Ports: clk, reset (async, active-high); i_start/o_ready accept handshake;
// i_is_signed selects DIV/REM vs DIVU/REMU; i_dividend/i_divisor are sampled on accept;
// i_flush aborts; o_valid pulses for one cycle with o_quotient/o_remainder.
module iter_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic         i_is_signed,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  input  logic         i_flush,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
  state_t r_state, w_next;
  logic [W:0] r_p;
  logic [W-1:0] r_q, r_d;
  logic [CW-1:0] r_cnt;
  logic r_qneg, r_rneg;
  logic w_a_neg, w_b_neg, w_zero, w_ovf, w_accept;
  logic [W-1:0] w_a_mag, w_b_mag, w_qres, w_rres;
  logic [W:0] w_ps, w_pn, w_rfix;
  assign w_a_neg  = i_is_signed & i_dividend[W-1];
  assign w_b_neg  = i_is_signed & i_divisor[W-1];
  // The most negative value maps to 100..0, which is its correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_mag  = w_b_neg ? -i_divisor : i_divisor;
  assign w_zero   = i_divisor == '0;
  assign w_ovf    = i_is_signed & (i_dividend == {1'b1, {(W-1){1'b0}}}) & (&i_divisor);
  assign w_accept = (r_state == IDLE) & i_start & ~i_flush;
  // Add or subtract decided by the sign of the partial remainder before the shift.
  assign w_ps     = {r_p[W-1:0], r_q[W-1]};
  assign w_pn     = r_p[W] ? w_ps + {1'b0, r_d} : w_ps - {1'b0, r_d};
  assign w_rfix   = r_p[W] ? r_p + {1'b0, r_d} : r_p;
  assign w_qres   = r_qneg ? -r_q : r_q;
  assign w_rres   = r_rneg ? -w_rfix[W-1:0] : w_rfix[W-1:0];
  always_comb begin
    w_next = i_flush ? IDLE :
             r_state == IDLE ? (i_start ? ((w_zero | w_ovf) ? DONE : DIV) : IDLE) :
             r_state == DIV  ? (r_cnt == '0 ? FIX : DIV) :
             r_state == FIX  ? DONE : IDLE;
    o_ready = r_state == IDLE;
    o_valid = (r_state == DONE) & ~i_flush;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else if (w_accept) begin
      r_qneg <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
      r_p    <= '0;
      r_q    <= w_a_mag;
      r_d    <= w_b_mag;
      r_cnt  <= CW'(W - 1);
      if (w_zero) begin
        o_quotient  <= '1;
        o_remainder <= i_dividend;
      end else if (w_ovf) begin
        o_quotient  <= i_dividend;
        o_remainder <= '0;
      end
    end else if (!i_flush && r_state == DIV) begin
      r_p   <= w_pn;
      r_q   <= {r_q[W-2:0], ~w_pn[W]};
      r_cnt <= r_cnt - 1'b1;
    end else if (!i_flush && r_state == FIX) begin
      o_quotient  <= w_qres;
      o_remainder <= w_rres;
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed table, handshake corner cases and random model compare for iter_divider
module tb_iter_divider;
  logic clk = 0, reset = 1, i_start = 0, i_is_signed = 0, i_flush = 0;
  logic [31:0] i_dividend = 0, i_divisor = 0;
  logic o_ready, o_valid;
  logic [31:0] o_quotient, o_remainder;
  int checks = 0, errors = 0;
  iter_divider #(.W(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_is_signed(i_is_signed),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_flush(i_flush),
    .o_ready(o_ready), .o_valid(o_valid), .o_quotient(o_quotient), .o_remainder(o_remainder)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic s;
    logic [31:0] a, b, q, r;
    int lat;
  } vec_t;
  vec_t v[14];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic no_valid(string nm, int cyc);
    logic seen = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      #1 if (o_valid) seen = 1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask
  task automatic run_op(string nm, logic s, logic [31:0] a, logic [31:0] b,
                        logic [31:0] eq, logic [31:0] er, int elat);
    int n = 0;
    logic busy_ok = 1;
    @(negedge clk);
    chk({nm, " ready_before"}, 32'(o_ready), 32'd1);
    i_start = 1; i_is_signed = s; i_dividend = a; i_divisor = b;
    @(posedge clk);
    #1 i_start = 0; i_dividend = $urandom; i_divisor = $urandom;
    while (!o_valid && n < 100) begin
      if (o_ready) busy_ok = 0;
      @(posedge clk);
      #1 n++;
    end
    chk({nm, " latency"}, 32'(n), 32'(elat));
    chk({nm, " quotient"}, o_quotient, eq);
    chk({nm, " remainder"}, o_remainder, er);
    chk({nm, " busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    #1 chk({nm, " ready_after"}, 32'(o_ready), 32'd1);
    chk({nm, " valid_after"}, 32'(o_valid), 32'd0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [31:0] pq, pr, a, b, eq, er;
    logic s;
    int n;
    v[0]  = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 33};
    v[1]  = '{1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    v[2]  = '{1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33};
    v[3]  = '{0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33};
    v[4]  = '{1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 0};
    v[5]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0};
    v[6]  = '{0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33};
    v[7]  = '{0, 32'd0, 32'd5, 32'd0, 32'd0, 33};
    v[8]  = '{1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 33};
    v[9]  = '{0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 0};
    v[10] = '{1, 32'h80000000, 32'd1, 32'h80000000, 32'd0, 33};
    v[11] = '{0, 32'd5, 32'd10, 32'd0, 32'd5, 33};
    v[12] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 33};
    v[13] = '{1, 32'h80000000, 32'd2, 32'hC0000000, 32'd0, 33};
    repeat (2) @(posedge clk);
    #1 chk("reset ready", 32'(o_ready), 32'd1);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset quotient", o_quotient, 32'd0);
    chk("reset remainder", o_remainder, 32'd0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), v[i].s, v[i].a, v[i].b, v[i].q, v[i].r, v[i].lat);
    // flush in the middle of a division
    pq = o_quotient; pr = o_remainder;
    @(negedge clk);
    i_start = 1; i_is_signed = 0; i_dividend = 1000; i_divisor = 3;
    @(posedge clk);
    #1 i_start = 0;
    repeat (9) @(posedge clk);
    #1 i_flush = 1;
    #1 chk("flush valid_low", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1 i_flush = 0;
    chk("flush ready", 32'(o_ready), 32'd1);
    no_valid("flush no_valid", 40);
    chk("flush quotient_kept", o_quotient, pq);
    chk("flush remainder_kept", o_remainder, pr);
    run_op("after_flush 9/3", 0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    // flush and start together in IDLE: no accept
    @(negedge clk);
    i_flush = 1; i_start = 1; i_dividend = 8; i_divisor = 2;
    @(posedge clk);
    #1 chk("flush_start ready", 32'(o_ready), 32'd1);
    i_flush = 0; i_start = 0;
    no_valid("flush_start no_valid", 40);
    // start pulses while busy in DIV and in DONE are ignored
    @(negedge clk);
    i_start = 1; i_is_signed = 0; i_dividend = 100; i_divisor = 7;
    @(posedge clk);
    #1 i_start = 0;
    n = 0;
    while (!o_valid && n < 100) begin
      if (n == 5) begin i_start = 1; i_dividend = 1; i_divisor = 1; end
      if (n == 6) i_start = 0;
      @(posedge clk);
      #1 n++;
    end
    chk("busy latency", 32'(n), 32'd33);
    i_start = 1; i_is_signed = 1; i_dividend = 2; i_divisor = 0;
    @(posedge clk);
    #1 chk("busy done_start_ignored", 32'(o_ready), 32'd1);
    i_start = 0;
    chk("busy quotient", o_quotient, 32'd14);
    chk("busy remainder", o_remainder, 32'd2);
    run_op("b2b 50/5", 0, 32'd50, 32'd5, 32'd10, 32'd0, 33);
    run_op("b2b 51/5", 0, 32'd51, 32'd5, 32'd10, 32'd1, 33);
    // asynchronous reset mid-division
    @(negedge clk);
    i_start = 1; i_is_signed = 0; i_dividend = 1000; i_divisor = 3;
    @(posedge clk);
    #1 i_start = 0;
    repeat (5) @(posedge clk);
    #2 reset = 1;
    #1 chk("areset ready", 32'(o_ready), 32'd1);
    chk("areset valid", 32'(o_valid), 32'd0);
    chk("areset quotient", o_quotient, 32'd0);
    chk("areset remainder", o_remainder, 32'd0);
    @(negedge clk) reset = 0;
    no_valid("areset no_valid", 40);
    // random compare against a behavioural model
    for (int i = 0; i < 25; i++) begin
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      if (b == 0) begin eq = 32'hFFFFFFFF; er = a; end
      else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin eq = a; er = 0; end
      else if (s) begin eq = $signed(a) / $signed(b); er = $signed(a) % $signed(b); end
      else begin eq = a / b; er = a % b; end
      run_op($sformatf("rnd%0d s%0d %h/%h", i, s, a, b), s, a, b, eq, er,
             (b == 0 || (s && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 0 : 33);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
